// File: rtl/irq_ctl_pkg.sv
// Shared constants and types for the interrupt controller.
package irq_ctl_pkg;

  // Register word indices.
  localparam logic [5:0] REG_PENDING   = 6'd0;
  localparam logic [5:0] REG_ENABLE    = 6'd1;
  localparam logic [5:0] REG_MODE      = 6'd2;
  localparam logic [5:0] REG_THRESHOLD = 6'd3;
  localparam logic [5:0] REG_CLAIM     = 6'd4;
  localparam logic [5:0] REG_PRIO_BASE = 6'd8;

  localparam int MAX_SRC = 31;

  // Gateway state per source.
  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_SERV = 2'd2
  } gw_state_e;

  // ID width: IDs run 0 (none) .. NUM_SRC, so NUM_SRC+1 distinct codes are
  // needed, hence $clog2(NUM_SRC+1). With NUM_SRC <= 31 this is at most 5.
  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: two-flop synchronizer, rising-edge detect, and the
// IDLE/PEND/SERV state machine with a separate edge-mode pending bit.
module irq_gateway
  import irq_ctl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      src,        // asynchronous request line
  input  logic      mode,       // 1 = edge, 0 = level
  input  logic      claim,      // this source won a CLAIM read
  input  logic      complete,   // COMPLETE write naming this source
  input  logic      mode_chg,   // MODE bit for this source is being changed
  output logic      pending,
  output gw_state_e state       // exposed for debug and SERV qualification
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       lvl;
  logic       rise;
  logic       pend_q;
  logic       pend_d;
  gw_state_e  state_d;

  assign lvl  = sync_q[1];
  assign rise = lvl & ~prev_q;

  // Synchronizer and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], src};
      prev_q <= lvl;
    end
  end

  // Next-state and pending-bit logic.
  always_comb begin
    pend_d  = pend_q;
    state_d = state;
    // Edge mode: a new rising edge wins over a claim clear in the same cycle.
    if (mode) begin
      pend_d = rise | (pend_q & ~claim);
      if (mode_chg) pend_d = 1'b0;
    end else begin
      pend_d = 1'b0;
    end
    case (state)
      GW_SERV: begin
        if (complete) state_d = (mode && pend_d) ? GW_PEND : GW_IDLE;
      end
      default: begin
        if (claim)      state_d = GW_SERV;
        else if (mode)  state_d = pend_d ? GW_PEND : GW_IDLE;
        else            state_d = lvl ? GW_PEND : GW_IDLE;
        // A mode change drops pending without touching in-service state.
        if (mode_chg && !claim) state_d = GW_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= GW_IDLE;
      pend_q <= 1'b0;
    end else begin
      state  <= state_d;
      pend_q <= pend_d;
    end
  end

  assign pending = mode ? pend_q : (state == GW_PEND);

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: register file, per-source gateways, combinational
// priority arbiter and registered exti output.
// Register access: reg_wr / reg_rd are single-cycle strobes with no
// backpressure; when both are high the write is dropped. Read data appears
// on reg_rdata the cycle after reg_rd and holds until the next read.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [5:0]         reg_addr,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               exti
);

  localparam int ID_W = id_width(NUM_SRC);

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] mode_q;
  logic [PRIO_W-1:0]  thresh_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_serv;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] complete_vec;
  logic [NUM_SRC-1:0] mode_chg;
  gw_state_e          gw_state [NUM_SRC];

  logic [NUM_SRC-1:0] win_vec;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               win_any;
  logic               wr_en;
  logic               rd_claim;
  logic [31:0]        rdata_d;

  assign wr_en    = reg_wr & ~reg_rd;
  assign rd_claim = reg_rd && (reg_addr == REG_CLAIM);

  // Per-source strobes derived from register accesses.
  always_comb begin
    complete_vec = '0;
    mode_chg     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      complete_vec[i] = wr_en && (reg_addr == REG_CLAIM) && (reg_wdata == 32'(i + 1));
      mode_chg[i]     = wr_en && (reg_addr == REG_MODE) && (reg_wdata[i] != mode_q[i]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : gen_gw
      irq_gateway u_gw (
        .clk      (clk),
        .rst      (rst),
        .src      (src[g]),
        .mode     (mode_q[g]),
        .claim    (claim_vec[g]),
        .complete (complete_vec[g]),
        .mode_chg (mode_chg[g]),
        .pending  (pending[g]),
        .state    (gw_state[g])
      );
      assign in_serv[g] = (gw_state[g] == GW_SERV);
    end
  endgenerate

  // Arbiter: highest priority wins, strict '>' keeps ties on the lowest index.
  always_comb begin
    eligible = '0;
    win_vec  = '0;
    win_id   = '0;
    win_prio = '0;
    win_any  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] & enable_q[i] & ~in_serv[i] & (prio_q[i] > thresh_q);
      if (eligible[i] && (!win_any || (prio_q[i] > win_prio))) begin
        win_any  = 1'b1;
        win_prio = prio_q[i];
        win_id   = ID_W'(i + 1);
        win_vec  = '0;
        win_vec[i] = 1'b1;
      end
    end
  end

  assign claim_vec = rd_claim ? win_vec : '0;

  // Writable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else if (wr_en) begin
      if (reg_addr == REG_ENABLE)    enable_q <= reg_wdata[NUM_SRC-1:0];
      if (reg_addr == REG_MODE)      mode_q   <= reg_wdata[NUM_SRC-1:0];
      if (reg_addr == REG_THRESHOLD) thresh_q <= reg_wdata[PRIO_W-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (reg_addr == REG_PRIO_BASE + 6'(i)) prio_q[i] <= reg_wdata[PRIO_W-1:0];
      end
    end
  end

  // Read data mux; unmapped indices and unimplemented bits read 0.
  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      REG_PENDING:   rdata_d = 32'(pending);
      REG_ENABLE:    rdata_d = 32'(enable_q);
      REG_MODE:      rdata_d = 32'(mode_q);
      REG_THRESHOLD: rdata_d = 32'(thresh_q);
      REG_CLAIM:     rdata_d = win_any ? 32'(win_id) : 32'd0;
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (reg_addr == REG_PRIO_BASE + 6'(i)) rdata_d = 32'(prio_q[i]);
        end
      end
    endcase
  end

  // Registered read data and interrupt request; a claimed winner is masked
  // so exti drops on the cycle after the claim.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rdata <= '0;
      exti      <= 1'b0;
    end else begin
      if (reg_rd) reg_rdata <= rdata_d;
      exti <= |(eligible & ~claim_vec);
    end
  end

endmodule
